blake2_round_ctrl: RTL and testbench

Sequences one BLAKE2 compression upstream of blake2_m_select. It accepts a 1024-bit message block over a valid/ready handshake and holds it stable on m for the whole compression. It steps the round index r and the column/diagonal half-round flag state. It also issues the strobes that the G-function datapath uses to initialise the working vector, run half-rounds and finalise.

---
 rtl/blake2_round_ctrl.sv | 92 +++++++++
 tb/tb_blake2_round_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/blake2_round_ctrl.sv
// Sequences one BLAKE2 compression: latches the message block, steps the round
// index and column/diagonal flag, and issues the init/round/finalize strobes.
module blake2_round_ctrl #(
  parameter int unsigned NUM_ROUNDS = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          block_valid,
  output logic          block_ready,
  input  logic [1023:0] block,
  input  logic          abort,
  output logic [1023:0] m,
  output logic [3:0]    r,
  output logic          state,
  output logic          init_v,
  output logic          g_en,
  output logic          finalize,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StInit, StRounds, StFinal} fsm_t;

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS - 1);

  fsm_t fsm;

  assign block_ready = (fsm == StIdle) && !abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm      <= StIdle;
      m        <= '0;
      r        <= '0;
      state    <= 1'b0;
      init_v   <= 1'b0;
      g_en     <= 1'b0;
      finalize <= 1'b0;
      busy     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      init_v   <= 1'b0;
      g_en     <= 1'b0;
      finalize <= 1'b0;
      unique case (fsm)
        StIdle: begin
          if (block_valid && !abort) begin
            m      <= block;
            r      <= '0;
            state  <= 1'b0;
            busy   <= 1'b1;
            init_v <= 1'b1;
            fsm    <= StInit;
          end
        end
        StInit: begin
          if (abort) begin
            fsm   <= StIdle;
            r     <= '0;
            state <= 1'b0;
            busy  <= 1'b0;
          end else begin
            g_en <= 1'b1;
            fsm  <= StRounds;
          end
        end
        StRounds: begin
          if (abort) begin
            fsm   <= StIdle;
            r     <= '0;
            state <= 1'b0;
            busy  <= 1'b0;
          end else if (state && (r == LastRound)) begin
            // Last diagonal half-round done: r/state hold through finalize.
            finalize <= 1'b1;
            fsm      <= StFinal;
          end else begin
            g_en  <= 1'b1;
            state <= ~state;
            if (state) r <= r + 4'd1;
          end
        end
        StFinal: begin
          fsm   <= StIdle;
          r     <= '0;
          state <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blake2_round_ctrl.sv
// Bench for blake2_round_ctrl: 12- and 10-round instances share one stimulus
// stream; each is checked against a cycles-since-acceptance reference model.
module tb_blake2_round_ctrl;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          block_valid = 1'b0;
  logic          abort = 1'b0;
  logic [1023:0] block = '0;

  logic          br [2];
  logic [1023:0] mo [2];
  logic [3:0]    ro [2];
  logic          so [2];
  logic          iv [2];
  logic          ge [2];
  logic          fi [2];
  logic          bu [2];

  int            nr [2] = '{12, 10};
  int            off [2];
  logic [1023:0] m_exp [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  blake2_round_ctrl #(.NUM_ROUNDS(12)) u_dut12 (
    .clk(clk), .reset(reset), .block_valid(block_valid), .block_ready(br[0]),
    .block(block), .abort(abort), .m(mo[0]), .r(ro[0]), .state(so[0]),
    .init_v(iv[0]), .g_en(ge[0]), .finalize(fi[0]), .busy(bu[0])
  );

  blake2_round_ctrl #(.NUM_ROUNDS(10)) u_dut10 (
    .clk(clk), .reset(reset), .block_valid(block_valid), .block_ready(br[1]),
    .block(block), .abort(abort), .m(mo[1]), .r(ro[1]), .state(so[1]),
    .init_v(iv[1]), .g_en(ge[1]), .finalize(fi[1]), .busy(bu[1])
  );

  task automatic chk(input string tag, input int k, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // off = cycles since acceptance (1 = init cycle), -1 when idle.
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int o;
      int n;
      logic eg;
      logic ef;
      int er;
      int es;
      o  = off[k];
      n  = nr[k];
      eg = (o >= 2) && (o <= 2 * n + 1);
      ef = (o == 2 * n + 2);
      er = eg ? (o - 2) / 2 : (ef ? n - 1 : 0);
      es = eg ? (o - 2) % 2 : (ef ? 1 : 0);
      chk("block_ready", k, 64'(br[k]), 64'((o < 0) && !abort));
      chk("busy",        k, 64'(bu[k]), 64'(o > 0));
      chk("init_v",      k, 64'(iv[k]), 64'(o == 1));
      chk("g_en",        k, 64'(ge[k]), 64'(eg));
      chk("finalize",    k, 64'(fi[k]), 64'(ef));
      chk("r",           k, 64'(ro[k]), 64'(er));
      chk("state",       k, 64'(so[k]), 64'(es));
      for (int w = 0; w < 16; w++)
        chk("m_word", k, mo[k][1023 - 64 * w -: 64], m_exp[k][1023 - 64 * w -: 64]);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (off[k] < 0) begin
        if (block_valid && !abort) begin
          off[k]   = 1;
          m_exp[k] = block;
        end
      end else if (abort || off[k] == 2 * nr[k] + 2) begin
        off[k] = -1;
      end else begin
        off[k]++;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      off[k]   = -1;
      m_exp[k] = '0;
    end
  endtask

  task automatic step(input logic v, input logic [1023:0] b, input logic a);
    block_valid = v;
    block       = b;
    abort       = a;
    #1;
    check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1023:0] rand_block();
    logic [1023:0] b;
    for (int i = 0; i < 32; i++) b[32 * i +: 32] = $urandom;
    return b;
  endfunction

  // Bounded idle stepping until dut0 reaches the given model offset.
  task automatic run_to(input int target);
    int n;
    n = 0;
    while (off[0] != target && n < 100) begin
      step(1'b0, block, 1'b0);
      n++;
    end
  endtask

  initial begin
    logic [1023:0] seq_blk;
    logic [1023:0] b2;
    for (int i = 0; i < 16; i++) seq_blk[1023 - 64 * i -: 64] = 64'(i);
    model_reset();

    // Reset held three cycles, then idle.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    // Single block, one-cycle valid.
    step(1'b1, seq_blk, 1'b0);
    repeat (30) step(1'b0, seq_blk, 1'b0);

    // Backpressure: second block held valid while busy.
    b2 = rand_block();
    step(1'b1, rand_block(), 1'b0);
    repeat (29) step(1'b1, b2, 1'b0);
    repeat (5) step(1'b0, b2, 1'b0);

    // Abort in idle blocks acceptance.
    step(1'b1, rand_block(), 1'b1);
    step(1'b0, block, 1'b0);

    // Abort at (r,state) = (5,1), then immediate re-acceptance.
    step(1'b1, rand_block(), 1'b0);
    run_to(13);
    step(1'b0, block, 1'b1);
    step(1'b1, rand_block(), 1'b0);
    repeat (30) step(1'b0, block, 1'b0);

    // Abort coinciding with finalize.
    step(1'b1, rand_block(), 1'b0);
    run_to(26);
    step(1'b0, block, 1'b1);
    repeat (3) step(1'b0, block, 1'b0);

    // Asynchronous reset at r = 7, checked before any clock edge.
    step(1'b1, rand_block(), 1'b0);
    run_to(16);
    reset = 1'b1;
    #2;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, rand_block(), 1'b0);
    repeat (30) step(1'b0, block, 1'b0);

    // Random valid/abort traffic.
    for (int i = 0; i < 600; i++) begin
      logic v;
      logic a;
      v = 1'($urandom % 2);
      a = ($urandom % 32) == 0;
      step(v, ($urandom % 4 == 0) ? rand_block() : block, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
